// File: rtl/action_ram_pkg.sv
// Shared constants and FSM state type for the action-value RAM arbiter.
package action_ram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH      = 64;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_e;

endpackage

// File: rtl/action_ram_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips only on contention.
module action_ram_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt   = ptr_q ? 2'b10 : 2'b01;
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/action_ram_arbiter.sv
// Two-master read/write arbiter for the action-value RAM.
// Define ACTION_RAM_CLEAR_EN to sweep the table to zero after reset.
module action_ram_arbiter
  import action_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              run;
  logic [1:0]        rd_req, wr_req, rd_gnt, wr_gnt;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
`ifdef ACTION_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  // Grants are gated by reset so every output sits at its reset value while rst_n is low.
  assign run    = rst_n && (state_q == S_RUN);
  assign rd_req = {m1_req & ~m1_we, m0_req & ~m0_we} & {2{run}};
  assign wr_req = {m1_req &  m1_we, m0_req &  m0_we} & {2{run}};

  action_ram_rr_arb u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  action_ram_rr_arb u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  always_comb begin
    state_d   = state_q;
    rvalid_d  = rd_gnt;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    ram_en    = |rd_gnt;
    ram_we    = |wr_gnt;
    ram_wdata = '0;
    if (rd_gnt[1]) begin
      rd_addr_d = m1_addr;
    end else if (rd_gnt[0]) begin
      rd_addr_d = m0_addr;
    end
    if (wr_gnt[1]) begin
      wr_addr_d = m1_addr;
      ram_wdata = m1_wdata;
    end else if (wr_gnt[0]) begin
      wr_addr_d = m0_addr;
      ram_wdata = m0_wdata;
    end
`ifdef ACTION_RAM_CLEAR_EN
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      ram_we     = rst_n;
      wr_addr_d  = clr_addr_q;
      ram_wdata  = '0;
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == '1) begin
        state_d = S_RUN;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef ACTION_RAM_CLEAR_EN
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
`else
      state_q    <= S_RUN;
`endif
      rvalid_q   <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
`ifdef ACTION_RAM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      state_q    <= state_d;
      rvalid_q   <= rvalid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // Idle cycles present the last issued addresses rather than zero.
  assign ram_rd_addr = rd_addr_d;
  assign ram_wr_addr = wr_addr_d;

  assign m0_gnt    = rd_gnt[0] | wr_gnt[0];
  assign m1_gnt    = rd_gnt[1] | wr_gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

`ifdef ACTION_RAM_CLEAR_EN
  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_action_ram_arbiter.sv
// Randomized and directed bench for action_ram_arbiter with a behavioural RAM and reference model.
module tb_action_ram_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
`ifdef ACTION_RAM_CLEAR_EN
  localparam logic EXP_RST_BUSY = 1'b1;
`else
  localparam logic EXP_RST_BUSY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] ram_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            rd_ptr, wr_ptr;
  int            clear_left;
  bit            nxt_rv0, nxt_rv1;
  logic [DW-1:0] nxt_word;

  // Master intents
  bit            p_req [2];
  bit            p_we  [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];

  // Per-cycle expected and observed values
  logic          e_g [2], e_rv [2];
  logic          e_en, e_we, e_busy;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata, e_word;
  logic          o_g [2], o_rv [2];
  logic          o_en, o_we, o_busy;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic [DW-1:0] o_rdata [2];

  action_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .ram_en      (ram_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_addr (ram_wr_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, old data on same-address collision
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wr_addr] <= ram_wdata;
    if (ram_en) ram_rdata <= ram_mem[ram_rd_addr];
  end

  task automatic model_reset();
    rd_ptr  = 1'b0;
    wr_ptr  = 1'b0;
    nxt_rv0 = 1'b0;
    nxt_rv1 = 1'b0;
`ifdef ACTION_RAM_CLEAR_EN
    clear_left = DEPTH;
`else
    clear_left = 0;
`endif
    p_req = '{1'b0, 1'b0};
  endtask

  task automatic drive();
    m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
  endtask

  // One clock from negedge to negedge: drive, predict, sample, then update the model
  task automatic tick();
    bit rc0, rc1, wc0, wc1, gr0, gr1, gw0, gw1;
    drive();
    #1;
    e_rv[0] = nxt_rv0; e_rv[1] = nxt_rv1; e_word = nxt_word;
    e_busy = (clear_left > 0);
    rc0 = p_req[0] && !p_we[0]; rc1 = p_req[1] && !p_we[1];
    wc0 = p_req[0] &&  p_we[0]; wc1 = p_req[1] &&  p_we[1];
    gr0 = 0; gr1 = 0; gw0 = 0; gw1 = 0;
    if (clear_left > 0) begin
      e_we = 1'b1; e_en = 1'b0;
      e_waddr = AW'(DEPTH - clear_left);
      e_wdata = '0;
    end else begin
      if (rc0 && rc1) begin gr0 = !rd_ptr; gr1 = rd_ptr; end
      else begin gr0 = rc0; gr1 = rc1; end
      if (wc0 && wc1) begin gw0 = !wr_ptr; gw1 = wr_ptr; end
      else begin gw0 = wc0; gw1 = wc1; end
      e_en = gr0 || gr1;
      e_we = gw0 || gw1;
      e_waddr = gw0 ? p_addr[0] : p_addr[1];
      e_wdata = gw0 ? p_wdata[0] : p_wdata[1];
    end
    e_g[0] = gr0 || gw0; e_g[1] = gr1 || gw1;
    o_g[0] = m0_gnt; o_g[1] = m1_gnt; o_rv[0] = m0_rvalid; o_rv[1] = m1_rvalid;
    o_rdata[0] = m0_rdata; o_rdata[1] = m1_rdata;
    o_en = ram_en; o_we = ram_we; o_waddr = ram_wr_addr; o_wdata = ram_wdata; o_busy = busy;
    @(posedge clk);
    nxt_rv0 = 1'b0; nxt_rv1 = 1'b0;
    if (clear_left > 0) begin
      ref_mem[e_waddr] = '0;
      clear_left--;
    end else begin
      if (rc0 && rc1) rd_ptr = !rd_ptr;
      if (wc0 && wc1) wr_ptr = !wr_ptr;
      if (gr0 || gr1) begin
        nxt_word = ref_mem[gr0 ? p_addr[0] : p_addr[1]];
        nxt_rv0 = gr0; nxt_rv1 = gr1;
      end
      if (gw0 || gw1) ref_mem[e_waddr] = e_wdata;
      if (e_g[0]) p_req[0] = 1'b0;
      if (e_g[1]) p_req[1] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    p_req = '{1'b1, 1'b1}; p_we = '{1'b0, 1'b1}; p_addr = '{6'd1, 6'd2}; p_wdata = '{16'h0, 16'hAAAA};
    drive();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%b want=000000", {m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid});
    end
    total++;
    if (busy !== EXP_RST_BUSY) begin
      bad++; $display("[TB] FAIL reset_busy got=%b want=%b", busy, EXP_RST_BUSY);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clear();
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 6'd10;
    while (clear_left > 0) begin
      tick();
      total++;
      if (o_we !== 1'b1 || o_waddr !== e_waddr || o_wdata !== 16'h0) begin
        bad++; $display("[TB] FAIL clear_write got we=%b a=%0d d=%h want we=1 a=%0d d=0000", o_we, o_waddr, o_wdata, e_waddr);
      end
      total++;
      if (o_busy !== 1'b1 || o_g[0] !== 1'b0 || o_g[1] !== 1'b0) begin
        bad++; $display("[TB] FAIL clear_busy got busy=%b g=%b%b want busy=1 g=00", o_busy, o_g[0], o_g[1]);
      end
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_g[0] !== 1'b1 || o_en !== 1'b1) begin
      bad++; $display("[TB] FAIL first_grant got busy=%b g0=%b en=%b want busy=0 g0=1 en=1", o_busy, o_g[0], o_en);
    end
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rdata[0] !== e_word) begin
      bad++; $display("[TB] FAIL read_after_clear got rv=%b d=%h want rv=1 d=%h", o_rv[0], o_rdata[0], e_word);
    end
  endtask

  task automatic test_read_contention();
    logic eg0, eg1, erv0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        p_req = '{1'b1, 1'b1}; p_we = '{1'b0, 1'b0}; p_addr = '{6'd3, 6'd5};
      end else begin
        p_req = '{1'b0, 1'b0};
      end
      tick();
      eg0 = (i < 4) && (i % 2 == 0);
      eg1 = (i < 4) && (i % 2 == 1);
      total++;
      if (o_g[0] !== eg0 || o_g[1] !== eg1) begin
        bad++; $display("[TB] FAIL rd_contention_gnt i=%0d got=%b%b want=%b%b", i, o_g[0], o_g[1], eg0, eg1);
      end
      if (i > 0) begin
        erv0 = ((i - 1) % 2 == 0);
        total++;
        if (o_rv[0] !== erv0 || o_rv[1] !== !erv0 ||
            (erv0 ? o_rdata[0] : o_rdata[1]) !== (erv0 ? ref_mem[3] : ref_mem[5])) begin
          bad++; $display("[TB] FAIL rd_contention_rvalid i=%0d got rv=%b%b d=%h want rv=%b%b d=%h", i,
                          o_rv[0], o_rv[1], erv0 ? o_rdata[0] : o_rdata[1], erv0, !erv0,
                          erv0 ? ref_mem[3] : ref_mem[5]);
        end
      end
    end
  endtask

  task automatic test_concurrent();
    logic [DW-1:0] old7;
    old7 = ref_mem[7];
    p_req = '{1'b1, 1'b1}; p_we = '{1'b0, 1'b1}; p_addr = '{6'd7, 6'd9}; p_wdata[1] = 16'hBEEF;
    tick();
    total++;
    if (o_g[0] !== 1'b1 || o_g[1] !== 1'b1 || o_en !== 1'b1 || o_we !== 1'b1 || o_waddr !== 6'd9 || o_wdata !== 16'hBEEF) begin
      bad++; $display("[TB] FAIL concurrent_issue got g=%b%b en=%b we=%b a=%0d d=%h want g=11 en=1 we=1 a=9 d=beef",
                      o_g[0], o_g[1], o_en, o_we, o_waddr, o_wdata);
    end
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 6'd9;
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rv[1] !== 1'b0 || o_rdata[0] !== old7) begin
      bad++; $display("[TB] FAIL concurrent_old got rv=%b%b d=%h want rv=10 d=%h", o_rv[0], o_rv[1], o_rdata[0], old7);
    end
    p_req = '{1'b0, 1'b0};
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rdata[0] !== 16'hBEEF) begin
      bad++; $display("[TB] FAIL concurrent_new got rv=%b d=%h want rv=1 d=beef", o_rv[0], o_rdata[0]);
    end
  endtask

  task automatic test_hazard();
    p_req = '{1'b0, 1'b1}; p_we[1] = 1'b1; p_addr[1] = 6'd2; p_wdata[1] = 16'h0F0F;
    tick();
    p_req = '{1'b1, 1'b1}; p_we = '{1'b0, 1'b1}; p_addr = '{6'd2, 6'd2}; p_wdata[1] = 16'h1234;
    tick();
    total++;
    if (o_g[0] !== 1'b1 || o_g[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL hazard_gnt got=%b%b want=11", o_g[0], o_g[1]);
    end
    p_req = '{1'b1, 1'b0}; p_we[0] = 1'b0; p_addr[0] = 6'd2;
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rdata[0] !== 16'h0F0F) begin
      bad++; $display("[TB] FAIL hazard_old got rv=%b d=%h want rv=1 d=0f0f", o_rv[0], o_rdata[0]);
    end
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rdata[0] !== 16'h1234) begin
      bad++; $display("[TB] FAIL hazard_new got rv=%b d=%h want rv=1 d=1234", o_rv[0], o_rdata[0]);
    end
  endtask

  task automatic test_write_contention();
    p_req = '{1'b1, 1'b1}; p_we = '{1'b1, 1'b1}; p_addr = '{6'd4, 6'd4}; p_wdata = '{16'h1111, 16'h2222};
    tick();
    total++;
    if (o_g[0] !== 1'b1 || o_g[1] !== 1'b0 || o_wdata !== 16'h1111 || o_waddr !== 6'd4) begin
      bad++; $display("[TB] FAIL wr_contention_first got g=%b%b a=%0d d=%h want g=10 a=4 d=1111", o_g[0], o_g[1], o_waddr, o_wdata);
    end
    tick();
    total++;
    if (o_g[0] !== 1'b0 || o_g[1] !== 1'b1 || o_wdata !== 16'h2222) begin
      bad++; $display("[TB] FAIL wr_contention_second got g=%b%b d=%h want g=01 d=2222", o_g[0], o_g[1], o_wdata);
    end
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 6'd4;
    tick();
    tick();
    total++;
    if (o_rv[0] !== 1'b1 || o_rdata[0] !== 16'h2222) begin
      bad++; $display("[TB] FAIL wr_contention_final got rv=%b d=%h want rv=1 d=2222", o_rv[0], o_rdata[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 9) < 7) begin
          p_req[m]   = 1'b1;
          p_we[m]    = 1'($urandom_range(0, 1));
          p_addr[m]  = AW'($urandom_range(0, 7));
          p_wdata[m] = DW'($urandom);
        end
      end
      tick();
      total++;
      if (o_g[0] !== e_g[0] || o_g[1] !== e_g[1] || o_en !== e_en || o_we !== e_we) begin
        bad++; $display("[TB] FAIL rand_issue c=%0d got g=%b%b en=%b we=%b want g=%b%b en=%b we=%b", c,
                        o_g[0], o_g[1], o_en, o_we, e_g[0], e_g[1], e_en, e_we);
      end
      if (e_we) begin
        total++;
        if (o_waddr !== e_waddr || o_wdata !== e_wdata) begin
          bad++; $display("[TB] FAIL rand_write c=%0d got a=%0d d=%h want a=%0d d=%h", c, o_waddr, o_wdata, e_waddr, e_wdata);
        end
      end
      total++;
      if (o_rv[0] !== e_rv[0] || o_rv[1] !== e_rv[1]) begin
        bad++; $display("[TB] FAIL rand_rvalid c=%0d got=%b%b want=%b%b", c, o_rv[0], o_rv[1], e_rv[0], e_rv[1]);
      end
      if (e_rv[0] || e_rv[1]) begin
        total++;
        if ((e_rv[0] ? o_rdata[0] : o_rdata[1]) !== e_word) begin
          bad++; $display("[TB] FAIL rand_rdata c=%0d got=%h want=%h", c, e_rv[0] ? o_rdata[0] : o_rdata[1], e_word);
        end
      end
    end
    p_req = '{1'b0, 1'b0};
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    p_req = '{1'b1, 1'b0}; p_we[0] = 1'b0; p_addr[0] = 6'd6;
    tick();
    drive();
    #1;
    total++;
    if (m0_rvalid !== 1'b1) begin
      bad++; $display("[TB] FAIL rvalid_before_reset got=%b want=1", m0_rvalid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid} !== 6'b0 || busy !== EXP_RST_BUSY) begin
      bad++; $display("[TB] FAIL reset_mid_read got=%b busy=%b want=000000 busy=%b",
                      {m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid}, busy, EXP_RST_BUSY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30 && clear_left > 0; i++) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b0 || busy !== EXP_RST_BUSY || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid_sweep got we=%b busy=%b want we=0 busy=%b", ram_we, busy, EXP_RST_BUSY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n = 0;
    while (clear_left > 0) begin
      tick();
      total++;
      if (o_we !== 1'b1 || o_waddr !== AW'(n) || o_wdata !== 16'h0) begin
        bad++; $display("[TB] FAIL sweep_restart got we=%b a=%0d d=%h want we=1 a=%0d d=0000", o_we, o_waddr, o_wdata, n);
      end
      n++;
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_we !== 1'b0 || o_en !== 1'b0) begin
      bad++; $display("[TB] FAIL after_restart got busy=%b we=%b en=%b want 0 0 0", o_busy, o_we, o_en);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = DW'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    p_req = '{1'b0, 1'b0}; p_we = '{1'b0, 1'b0}; p_addr = '{6'd0, 6'd0}; p_wdata = '{16'h0, 16'h0};
    nxt_word = '0;
    model_reset();
    test_reset();
    test_clear();
    test_read_contention();
    test_concurrent();
    test_hazard();
    test_write_contention();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
